// File: rtl/modbus_req_sequencer.sv
// modbus_req_sequencer: per-frame sequencer for the Modbus RTU slave request path.
// Waits for CRC and request check after each received frame, then either drops
// the frame or launches one response job, and blocks new frames until tx_done.
// Optional: define MB_SEQ_TIMEOUT_EN to build the CRC_WAIT/TX_WAIT watchdog
// that drives seq_abort; without it seq_abort is constant 0.
module modbus_req_sequencer #(
   parameter logic [7:0]  SLAVE_ID   = 8'h01,
   parameter int          CHK_WINDOW = 8,
   parameter logic [15:0] TX_TIMEOUT = 16'hFFFF
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       rx_message_done,
   input  logic [7:0] rx_station,
   input  logic [7:0] func_code,
   input  logic       crc_done,
   input  logic       exception_done,
   input  logic [7:0] exception,
   input  logic       tx_done,
   output logic       busy,
   output logic       resp_start,
   output logic       resp_exc,
   output logic [7:0] resp_func,
   output logic [7:0] resp_code,
   output logic       frame_drop,
   output logic       frame_overrun,
   output logic       seq_abort
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CRC_WAIT = 3'd1,
      S_CHK_WAIT = 3'd2,
      S_DISPATCH = 3'd3,
      S_TX_WAIT  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] station_q, station_d;
   logic [7:0] func_q, func_d;
   logic [7:0] cnt_q, cnt_d;
   logic       busy_q, busy_d;
   logic       start_q, start_d;
   logic       exc_q, exc_d;
   logic [7:0] rfunc_q, rfunc_d;
   logic [7:0] code_q, code_d;
   logic       drop_q, drop_d;
   logic       ovr_q, ovr_d;
`ifdef MB_SEQ_TIMEOUT_EN
   logic [15:0] wd_q, wd_d;
   logic        abort_q, abort_d;
`endif

   // Next-state and next-output logic; every output is taken from a flop.
   always_comb begin
      state_d   = state_q;
      station_d = station_q;
      func_d    = func_q;
      cnt_d     = cnt_q;
      exc_d     = exc_q;
      rfunc_d   = rfunc_q;
      code_d    = code_q;
      start_d   = 1'b0;
      drop_d    = 1'b0;
      // A frame arriving while a previous one is in flight is never latched.
      ovr_d     = rx_message_done && (state_q != S_IDLE);
`ifdef MB_SEQ_TIMEOUT_EN
      wd_d      = wd_q;
      abort_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (rx_message_done) begin
               station_d = rx_station;
               func_d    = func_code;
               if (rx_station == SLAVE_ID || rx_station == 8'h00) begin
                  state_d = S_CRC_WAIT;
`ifdef MB_SEQ_TIMEOUT_EN
                  wd_d    = 16'd0;
`endif
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         S_CRC_WAIT: begin
            if (crc_done) begin
               state_d = S_CHK_WAIT;
               cnt_d   = 8'd0;
            end
`ifdef MB_SEQ_TIMEOUT_EN
            else if (wd_q == TX_TIMEOUT - 16'd1) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + 16'd1;
            end
`endif
         end
         S_CHK_WAIT: begin
            // exception_done has priority over the window running out.
            if (exception_done) begin
               code_d  = exception;
               state_d = S_DISPATCH;
               // Outputs are registered, so the DISPATCH-cycle pulses are
               // decided on the edge that enters DISPATCH.
               if (station_q == 8'h00) begin
                  drop_d = 1'b1;
               end else begin
                  start_d = 1'b1;
                  exc_d   = |exception;
                  rfunc_d = func_q | {|exception, 7'b0};
               end
            end else if (cnt_q == 8'(CHK_WINDOW - 1)) begin
               drop_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DISPATCH: begin
            if (station_q == 8'h00) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_TX_WAIT;
`ifdef MB_SEQ_TIMEOUT_EN
               wd_d    = 16'd0;
`endif
            end
         end
         S_TX_WAIT: begin
            if (tx_done) begin
               state_d = S_IDLE;
            end
`ifdef MB_SEQ_TIMEOUT_EN
            else if (wd_q == TX_TIMEOUT - 16'd1) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + 16'd1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, latches and registered outputs; async reset clears everything.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= S_IDLE;
         station_q <= 8'd0;
         func_q    <= 8'd0;
         cnt_q     <= 8'd0;
         busy_q    <= 1'b0;
         start_q   <= 1'b0;
         exc_q     <= 1'b0;
         rfunc_q   <= 8'd0;
         code_q    <= 8'd0;
         drop_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef MB_SEQ_TIMEOUT_EN
         wd_q      <= 16'd0;
         abort_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         station_q <= station_d;
         func_q    <= func_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         start_q   <= start_d;
         exc_q     <= exc_d;
         rfunc_q   <= rfunc_d;
         code_q    <= code_d;
         drop_q    <= drop_d;
         ovr_q     <= ovr_d;
`ifdef MB_SEQ_TIMEOUT_EN
         wd_q      <= wd_d;
         abort_q   <= abort_d;
`endif
      end
   end

   assign busy          = busy_q;
   assign resp_start    = start_q;
   assign resp_exc      = exc_q;
   assign resp_func     = rfunc_q;
   assign resp_code     = code_q;
   assign frame_drop    = drop_q;
   assign frame_overrun = ovr_q;
`ifdef MB_SEQ_TIMEOUT_EN
   assign seq_abort     = abort_q;
`else
   // No watchdog: constant 0; TX_TIMEOUT is kept only for a uniform interface.
   assign seq_abort     = 1'b0 & (|TX_TIMEOUT);
`endif

endmodule

// File: tb/tb_modbus_req_sequencer.sv
// Randomized bench for modbus_req_sequencer. Each frame is described by its
// event schedule (rx, crc, exception, tx times); expected outputs are placed
// on the cycle timeline from those event times.
module tb_modbus_req_sequencer;

   localparam logic [7:0] SID = 8'h01;
   localparam int         W   = 8;
   localparam int         TMO = 16;

   logic       clk_in = 1'b0;
   logic       rst_n_in = 1'b0;
   logic       rx_message_done = 1'b0;
   logic [7:0] rx_station = 8'd0;
   logic [7:0] func_code = 8'd0;
   logic       crc_done = 1'b0;
   logic       exception_done = 1'b0;
   logic [7:0] exception = 8'd0;
   logic       tx_done = 1'b0;
   logic       busy, resp_start, resp_exc, frame_drop, frame_overrun, seq_abort;
   logic [7:0] resp_func, resp_code;

   int         checks = 0;
   int         failures = 0;
   string      phase = "reset";

   // Held-output model
   logic       m_exc = 1'b0;
   logic [7:0] m_func = 8'd0;
   logic [7:0] m_code = 8'd0;

   modbus_req_sequencer #(.SLAVE_ID(SID), .CHK_WINDOW(W), .TX_TIMEOUT(16'(TMO))) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .rx_message_done(rx_message_done), .rx_station(rx_station), .func_code(func_code),
      .crc_done(crc_done), .exception_done(exception_done), .exception(exception),
      .tx_done(tx_done), .busy(busy), .resp_start(resp_start), .resp_exc(resp_exc),
      .resp_func(resp_func), .resp_code(resp_code), .frame_drop(frame_drop),
      .frame_overrun(frame_overrun), .seq_abort(seq_abort)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_outs(input bit b, input bit s, input bit d, input bit o, input bit a);
      chk({phase, ".busy"},     32'(busy),          32'(b));
      chk({phase, ".start"},    32'(resp_start),    32'(s));
      chk({phase, ".drop"},     32'(frame_drop),    32'(d));
      chk({phase, ".overrun"},  32'(frame_overrun), 32'(o));
      chk({phase, ".abort"},    32'(seq_abort),     32'(a));
      chk({phase, ".resp_exc"}, 32'(resp_exc),      32'(m_exc));
      chk({phase, ".resp_func"},32'(resp_func),     32'(m_func));
      chk({phase, ".resp_code"},32'(resp_code),     32'(m_code));
   endtask

   task automatic clear_pulses();
      rx_message_done = 1'b0;
      crc_done        = 1'b0;
      exception_done  = 1'b0;
      tx_done         = 1'b0;
   endtask

   // One frame. d1: crc delay after entering CRC_WAIT (<0 = withheld);
   // k: exception_done offset after crc_done (0 = never); d2: tx delay after
   // entering TX_WAIT (<0 = withheld); ov: 0 none, -1 random, >0 overrun cycle.
   task automatic frame(input logic [7:0] st, input logic [7:0] fc, input int d1,
                        input int k, input logic [7:0] ev, input int d2, input int ov);
      bit         eb[64], es[64], ed[64], eo[64], ea[64];
      bit         rx[64], cr[64], xd[64], td[64];
      logic [7:0] rs[64], rf[64], xv[64];
      int         C, E, X, L, s, ce;
      bit         fg, bc;
      C = -1; E = -1; X = -1; L = 1;
      fg = !(st == SID || st == 8'h00);
      bc = (st == 8'h00);
      for (int j = 0; j < 64; j++) begin
         eb[j] = 0; es[j] = 0; ed[j] = 0; eo[j] = 0; ea[j] = 0;
         rx[j] = 0; cr[j] = 0; xd[j] = 0; td[j] = 0;
         rs[j] = 8'($urandom); rf[j] = 8'($urandom); xv[j] = 8'($urandom);
      end
      rx[0] = 1; rs[0] = st; rf[0] = fc;
      if (fg) begin
         L = 1; ed[1] = 1;
      end else begin
         if (d1 < 0) begin
            L = 1 + TMO; ea[L] = 1;
         end else begin
            C = 1 + d1;
            if (k == 0) begin
               L = C + W + 1; ed[L] = 1;
            end else begin
               E = C + k;
               if (bc) begin
                  ed[E+1] = 1; L = E + 2;
               end else begin
                  es[E+1] = 1;
                  if (d2 < 0) begin L = E + 2 + TMO; ea[L] = 1; end
                  else begin X = E + 2 + d2; L = X + 1; end
               end
            end
         end
         for (int j = 1; j < L; j++) eb[j] = 1;
         // Pulses that arrive outside their wait state and must be ignored
         if (C > 0) td[$urandom_range(0, C)] = 1;
         if (C > 1) xd[$urandom_range(1, C - 1)] = 1;
         ce = (E >= 0) ? E - 1 : L - 1;
         if (C >= 0 && ce >= C + 1) cr[$urandom_range(C + 1, ce)] = 1;
         if (C >= 0) cr[C] = 1;
         if (E >= 0) begin xd[E] = 1; xv[E] = ev; end
         if (X >= 0) td[X] = 1;
      end
      if (L > 1 && ov != 0) begin
         s = (ov > 0) ? ov : $urandom_range(1, L - 1);
         rx[s] = 1; rs[s] = (s[0]) ? SID : 8'($urandom);
         eo[s+1] = 1;
      end
      for (int j = 0; j <= L; j++) begin
         if (j > 0) begin
            @(negedge clk_in);
            if (E >= 0 && j == E + 1) begin
               m_code = ev;
               if (!bc) begin
                  m_exc  = (ev != 8'd0);
                  m_func = (ev != 8'd0) ? (fc | 8'h80) : fc;
               end
            end
            chk_outs(eb[j], es[j], ed[j], eo[j], ea[j]);
         end
         if (j < L) begin
            rx_message_done = rx[j]; rx_station = rs[j]; func_code = rf[j];
            crc_done = cr[j]; exception_done = xd[j]; exception = xv[j]; tx_done = td[j];
         end
      end
      clear_pulses();
   endtask

   // Idle cycles with stray crc/exception/tx pulses that must change nothing.
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         rx_message_done = 1'b0;
         crc_done = 1'($urandom_range(0, 1));
         exception_done = 1'($urandom_range(0, 1));
         tx_done = 1'($urandom_range(0, 1));
         rx_station = 8'($urandom); func_code = 8'($urandom); exception = 8'($urandom);
         @(negedge clk_in);
         clear_pulses();
         chk_outs(0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      logic [7:0] st, ev;
      int r, k;
      // Reset state
      repeat (2) @(negedge clk_in);
      phase = "reset";
      chk_outs(0, 0, 0, 0, 0);
      rst_n_in = 1'b1;
      gap(2);

      phase = "good_read";   frame(SID, 8'h03, 1, 2, 8'h00, 3, 0);
      phase = "illegal_fn";  frame(SID, 8'h05, 0, 2, 8'h01, 2, 0);
      phase = "crc_mismatch";frame(SID, 8'h04, 2, 0, 8'h00, 0, 0);
      phase = "foreign";     frame(8'h07, 8'h03, 0, 0, 8'h00, 0, 0);
      phase = "broadcast";   frame(8'h00, 8'h06, 1, 3, 8'h00, 0, 0);
      phase = "win_edge";    frame(SID, 8'h10, 0, W, 8'h03, 1, 0);
      phase = "ovr_txwait";  frame(SID, 8'h03, 0, 2, 8'h00, 5, 7);
      phase = "ovr_txdone";  frame(SID, 8'h03, 0, 2, 8'h02, 5, 10);
      phase = "b2b";         frame(SID, 8'h01, 0, 1, 8'h00, 0, 0);
      gap(1);

`ifdef MB_SEQ_TIMEOUT_EN
      phase = "wd_tx";       frame(SID, 8'h03, 0, 2, 8'h00, -1, 0);
      phase = "wd_crc";      frame(SID, 8'h03, -1, 0, 8'h00, 0, 0);
      phase = "wd_crc_wins"; frame(SID, 8'h03, TMO - 1, 2, 8'h00, 1, 0);
      phase = "wd_tx_wins";  frame(SID, 8'h03, 0, 2, 8'h00, TMO - 1, 0);
`endif

      phase = "random";
      for (int n = 0; n < 150; n++) begin
         r  = $urandom_range(0, 9);
         st = (r < 6) ? SID : (r < 8) ? 8'h00 : 8'($urandom_range(2, 255));
         k  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, W);
         ev = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
         frame(st, 8'($urandom), $urandom_range(0, 5), k, ev, $urandom_range(0, 8),
               ($urandom_range(0, 2) == 0) ? -1 : 0);
         if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end

      // Reset in the middle of CHK_WAIT, with nonzero held outputs
      phase = "pre_rst";     frame(SID, 8'h05, 0, 1, 8'h01, 0, 0);
      phase = "rst_mid";
      rx_message_done = 1'b1; rx_station = SID; func_code = 8'h06;
      @(negedge clk_in); clear_pulses(); crc_done = 1'b1;
      @(negedge clk_in); clear_pulses();
      @(negedge clk_in);
      chk("rst_mid.busy_pre", 32'(busy), 32'd1);
      #2 rst_n_in = 1'b0;
      #1 m_exc = 1'b0; m_func = 8'd0; m_code = 8'd0;
      chk_outs(0, 0, 0, 0, 0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      gap(2);
      phase = "post_rst";    frame(SID, 8'h03, 1, 2, 8'h00, 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
